// File: rtl/pipeline_ctrl.sv
// Pipeline control: stall/flush/bubble steering for a 5-stage pipeline with
// a data-memory wait state, timeout halt and saturating performance counters.
module pipeline_ctrl #(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard_stall,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        mem_wb_bubble,
    output logic        mem_err,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              mem_err_reg;
    logic              freeze;
    logic              halted;
    logic [1:0]        cnt_inc;

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        freeze        = 1'b0;
        halted        = 1'b0;

        case (state_reg)
            RUN: begin
                if (mem_req && !mem_ack) begin
                    freeze     = 1'b1;
                    state_next = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                // mem_req is don't-care here; only the ack ends the wait
                if (mem_ack) begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt_reg == WAIT_LAST) begin
                        state_next    = HALT;
                        wait_cnt_next = '0;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + 1'b1;
                    end
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase

        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        mem_wb_bubble = 1'b0;

        // Priority: reset/halt, then memory freeze, then load-use stall, then branch
        if (rst || halted) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_en     = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (freeze) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (hazard_stall) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (branch_taken) begin
            if_id_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
            mem_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (state_next == HALT) begin
                mem_err_reg <= 1'b1;
            end
        end
    end

    assign mem_err = mem_err_reg;

    // Counter 0 counts PC-stalled cycles outside HALT, counter 1 counts IF/ID flushes
    assign cnt_inc[0] = !pc_en && (state_reg != HALT);
    assign cnt_inc[1] = if_id_flush;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf_cnt
            logic [31:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end
        end
    endgenerate

    assign stall_cnt = g_perf_cnt[0].cnt_reg;
    assign flush_cnt = g_perf_cnt[1].cnt_reg;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock; the only clock.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: hazard_stall  input  1  load-use stall request from the hazard detector.
REQ-004 SHALL have port: branch_taken  input  1  ID-stage branch/jump redirect.
REQ-005 SHALL have port: mem_req  input  1  MEM stage issuing a data-memory access.
REQ-006 SHALL have port: mem_ack  input  1  data memory completes the access this cycle.
REQ-007 SHALL have ports: pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  output  1 each  pipeline register write enables.
REQ-008 SHALL have ports: if_id_flush, id_ex_bubble, mem_wb_bubble  output  1 each  insert NOP into that register.
REQ-009 SHALL have port: mem_err  output  1  sticky memory-timeout flag.
REQ-010 SHALL have ports: stall_cnt, flush_cnt  output  32 each  performance counters.
REQ-011 SHALL have parameter: TIMEOUT, default 256, MEM_WAIT cycles before error.

Function
REQ-012 SHALL implement FSM states RUN, MEM_WAIT, HALT.
REQ-013 RUN, mem_req=1, mem_ack=0 SHALL go to MEM_WAIT; same cycle: pc_en=if_id_en=id_ex_en=ex_mem_en=0, mem_wb_en=1, mem_wb_bubble=1.
REQ-014 RUN, mem_req=1, mem_ack=1 (zero-wait) SHALL stay RUN with normal advance.
REQ-015 MEM_WAIT, mem_ack=0 SHALL hold the freeze pattern of REQ-013 and increment a wait counter.
REQ-016 MEM_WAIT, mem_ack=1 SHALL return to RUN; that cycle is a normal advance cycle (REQ-018..020 apply); mem_req ignored in MEM_WAIT.
REQ-017 Wait counter reaching TIMEOUT-1 with mem_ack=0 SHALL go to HALT and set mem_err next cycle; wait counter clears on leaving MEM_WAIT.
REQ-018 Normal advance, no hazard/branch: all five enables=1, all flush/bubble=0.
REQ-019 Normal advance with hazard_stall=1: pc_en=0, if_id_en=0, id_ex_en=1, id_ex_bubble=1, others advance.
REQ-020 Normal advance with branch_taken=1, hazard_stall=0: all enables=1, if_id_flush=1.
REQ-021 hazard_stall and branch_taken both 1: stall wins, if_id_flush=0.
REQ-022 Memory freeze SHALL override hazard_stall and branch_taken; both ignored while frozen.
REQ-023 HALT: all enables=0, all flush/bubble=1, exits only on rst; mem_err stays 1.
REQ-024 stall_cnt SHALL increment each cycle pc_en=0 in RUN or MEM_WAIT; not in HALT or reset.
REQ-025 flush_cnt SHALL increment each cycle if_id_flush=1.
REQ-026 Both counters SHALL saturate at 32'hFFFFFFFF, no wrap.
REQ-027 Control outputs SHALL be combinational from state and inputs; counters and mem_err registered.

Reset
REQ-028 rst=1 at a clock edge SHALL set state RUN, wait counter 0, mem_err 0, stall_cnt 0, flush_cnt 0.
REQ-029 While rst=1, outputs SHALL be: all enables=0, if_id_flush=id_ex_bubble=mem_wb_bubble=1.
REQ-030 rst in MEM_WAIT or HALT SHALL return to RUN next cycle with no pending wait.

Verification
REQ-031 Reset, then idle 5 cycles -> all enables 1, bubbles 0, stall_cnt=0, flush_cnt=0.
REQ-032 hazard_stall=1 for 1 cycle -> pc_en=0, if_id_en=0, id_ex_bubble=1 that cycle; stall_cnt=1.
REQ-033 mem_req=1, mem_ack after 3 cycles -> 3 frozen cycles with mem_wb_bubble=1, RUN on ack cycle, stall_cnt=3.
REQ-034 hazard_stall=1 and branch_taken=1 together -> if_id_flush=0, id_ex_bubble=1, flush_cnt unchanged.
REQ-035 mem_req=1, mem_ack never, TIMEOUT=4 -> HALT after 4 wait cycles, mem_err=1, stays until rst, then RUN with mem_err=0.
REQ-036 branch_taken=1 while frozen in MEM_WAIT -> if_id_flush=0, flush_cnt unchanged.
